// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch sequencer for the 8-bit processor.
// Owns the program counter. It requests instructions from memory (req/ack),
// holds each fetched word for the decoder (valid/ready) and advances or
// redirects the PC when the decoder takes an instruction (the handoff).
module pc_sequencer #(
  parameter int unsigned         PC_W     = 8,
  parameter int unsigned         INSTR_W  = 16,
  parameter logic [PC_W-1:0]     RESET_PC = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               halt_i,
  output logic               mem_req_o,
  output logic [PC_W-1:0]    mem_addr_o,
  input  logic               mem_ack_i,
  input  logic [INSTR_W-1:0] mem_data_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  input  logic               jump_en_i,
  input  logic [PC_W-1:0]    jump_addr_i,
  output logic [PC_W-1:0]    pc_o,
  output logic               pc_wrap_o,
  output logic [7:0]         retired_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HOLD   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 instr_valid_q, instr_valid_d;
  logic                 pc_wrap_q, pc_wrap_d;
  logic [7:0]           retired_q, retired_d;
  logic                 mem_req_q, mem_req_d;
  logic                 busy_q, busy_d;
  logic [PC_W:0]        pc_inc_s;
  logic                 handoff_s;

  // Modulo-2^W increment; the top bit is the carry out of the all-ones value.
  function automatic logic [PC_W:0] pc_increment(input logic [PC_W-1:0] value);
    pc_increment = {1'b0, value} + {{PC_W{1'b0}}, 1'b1};
  endfunction

  assign pc_inc_s  = pc_increment(pc_q);
  assign handoff_s = instr_valid_q & instr_ready_i;

  // Next-state and datapath decode; every register keeps its value by default.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    pc_wrap_d     = 1'b0;
    retired_d     = retired_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        // halt and jump are not looked at until the handoff.
        if (mem_ack_i) begin
          instr_d       = mem_data_i;
          instr_valid_d = 1'b1;
          state_d       = S_HOLD;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HOLD: begin
        if (handoff_s) begin
          if (jump_en_i) begin
            // A jump to 0 is not a wrap, so no pulse here.
            pc_d = jump_addr_i;
          end else begin
            pc_d      = pc_inc_s[PC_W-1:0];
            pc_wrap_d = pc_inc_s[PC_W];
          end
          retired_d     = retired_q + 8'd1;
          instr_valid_d = 1'b0;
          if (halt_i) begin
            state_d = S_HALTED;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HALTED: begin
        // start has priority over a simultaneous halt while halted.
        instr_valid_d = 1'b0;
        if (start_i) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_HALTED;
        end
      end
      default: begin
        state_d       = S_IDLE;
        instr_valid_d = 1'b0;
      end
    endcase
    mem_req_d = (state_d == S_FETCH);
    busy_d    = (state_d == S_FETCH) || (state_d == S_HOLD);
  end

  // State and output registers; reset discards any pending instruction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= {INSTR_W{1'b0}};
      instr_valid_q <= 1'b0;
      pc_wrap_q     <= 1'b0;
      retired_q     <= 8'd0;
      mem_req_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      pc_wrap_q     <= pc_wrap_d;
      retired_q     <= retired_d;
      mem_req_q     <= mem_req_d;
      busy_q        <= busy_d;
    end
  end

  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign pc_o          = pc_q;
  assign pc_wrap_o     = pc_wrap_q;
  assign retired_o     = retired_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed, table-driven bench for pc_sequencer.
module tb_pc_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, halt_i, mem_ack_i, instr_ready_i, jump_en_i;
  logic [15:0] mem_data_i;
  logic [7:0]  jump_addr_i;
  logic        mem_req_o, instr_valid_o, pc_wrap_o, busy_o;
  logic [7:0]  mem_addr_o, pc_o, retired_o;
  logic [15:0] instr_o;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(.PC_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i), .instr_o(instr_o), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .pc_o(pc_o), .pc_wrap_o(pc_wrap_o), .retired_o(retired_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic start, halt, ack;
    logic [15:0] data;
    logic ready, jen;
    logic [7:0] jaddr;
    logic req;
    logic [7:0] addr;
    logic vld;
    logic [15:0] ins;
    logic [7:0] pc;
    logic wrap;
    logic [7:0] ret;
    logic busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic st, input logic ht, input logic ak,
                              input logic [15:0] dt, input logic rd, input logic je,
                              input logic [7:0] ja, input logic rq, input logic [7:0] ad,
                              input logic vl, input logic [15:0] is, input logic [7:0] p,
                              input logic wr, input logic [7:0] rt, input logic bz);
    vec_t v;
    v.start = st; v.halt = ht; v.ack = ak; v.data = dt; v.ready = rd; v.jen = je;
    v.jaddr = ja; v.req = rq; v.addr = ad; v.vld = vl; v.ins = is; v.pc = p;
    v.wrap = wr; v.ret = rt; v.busy = bz;
    vecs.push_back(v);
  endfunction

  function automatic logic [43:0] snap();
    return {mem_req_o, mem_addr_o, instr_valid_o, instr_o, pc_o, pc_wrap_o, retired_o, busy_o};
  endfunction

  task automatic chk(input string name, input logic [43:0] act, input logic [43:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic ht, input logic ak, input logic [15:0] dt,
                       input logic rd, input logic je, input logic [7:0] ja);
    start_i = st; halt_i = ht; mem_ack_i = ak; mem_data_i = dt;
    instr_ready_i = rd; jump_en_i = je; jump_addr_i = ja;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0; halt_i = 1'b0; mem_ack_i = 1'b0; mem_data_i = 16'h0000;
    instr_ready_i = 1'b0; jump_en_i = 1'b0; jump_addr_i = 8'h00;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset_state", snap(), {1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0});
    rst_i = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 8'h00);
    chk("idle_no_start", snap(), {1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0});

    // Sequential fetch, zero-wait: one instruction every two cycles.
    //  st    ht    ak    data      rd    je    ja     req   addr  vld   instr     pc     wr    ret    busy
    add(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 8'd0, 1'b1);
    add(1'b0, 1'b0, 1'b1, 16'hA000, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 16'hA000, 8'h00, 1'b0, 8'd0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 16'hA000, 8'h01, 1'b0, 8'd1, 1'b1);
    add(1'b0, 1'b0, 1'b1, 16'hA001, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b1, 16'hA001, 8'h01, 1'b0, 8'd1, 1'b1);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 16'hA001, 8'h02, 1'b0, 8'd2, 1'b1);
    add(1'b0, 1'b0, 1'b1, 16'hA002, 1'b1, 1'b0, 8'h00, 1'b0, 8'h02, 1'b1, 16'hA002, 8'h02, 1'b0, 8'd2, 1'b1);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 16'hA002, 8'h03, 1'b0, 8'd3, 1'b1);
    add(1'b0, 1'b0, 1'b1, 16'hA003, 1'b1, 1'b0, 8'h00, 1'b0, 8'h03, 1'b1, 16'hA003, 8'h03, 1'b0, 8'd3, 1'b1);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 16'hA003, 8'h04, 1'b0, 8'd4, 1'b1);
    add(1'b0, 1'b0, 1'b1, 16'hA004, 1'b0, 1'b0, 8'h00, 1'b0, 8'h04, 1'b1, 16'hA004, 8'h04, 1'b0, 8'd4, 1'b1);
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 1'b0, 16'hA004, 8'h05, 1'b0, 8'd5, 1'b1);
    // Late ack at address 5: request held, halt/jump ignored in FETCH.
    for (int i = 0; i < 3; i++) begin
      add(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h99, 1'b1, 8'h05, 1'b0, 16'hA004, 8'h05, 1'b0, 8'd5, 1'b1);
    end
    add(1'b0, 1'b0, 1'b1, 16'hB005, 1'b0, 1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 16'hB005, 8'h05, 1'b0, 8'd5, 1'b1);
    // Decoder stall 4 cycles; stray acks in HOLD ignored.
    for (int i = 0; i < 4; i++) begin
      add(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 8'h00, 1'b0, 8'h05, 1'b1, 16'hB005, 8'h05, 1'b0, 8'd5, 1'b1);
    end
    add(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 8'h06, 1'b0, 16'hB005, 8'h06, 1'b0, 8'd6, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].halt, vecs[i].ack, vecs[i].data,
            vecs[i].ready, vecs[i].jen, vecs[i].jaddr);
      chk($sformatf("vec%0d", i), snap(),
          {vecs[i].req, vecs[i].addr, vecs[i].vld, vecs[i].ins, vecs[i].pc,
           vecs[i].wrap, vecs[i].ret, vecs[i].busy});
    end

    // PC wrap: jump to 254, then two sequential handoffs.
    drive(1'b0, 1'b0, 1'b1, 16'hC000, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 8'hFE);
    chk("jump_fe", {36'd0, pc_o}, {36'd0, 8'hFE});
    drive(1'b0, 1'b0, 1'b1, 16'hC001, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00);
    chk("pc_ff", {35'd0, pc_wrap_o, pc_o}, {35'd0, 1'b0, 8'hFF});
    drive(1'b0, 1'b0, 1'b1, 16'hC002, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00);
    chk("wrap_pulse", {27'd0, pc_wrap_o, pc_o, retired_o}, {27'd0, 1'b1, 8'h00, 8'd9});
    drive(1'b0, 1'b0, 1'b1, 16'hC003, 1'b0, 1'b0, 8'h00);
    chk("wrap_one_cycle", {43'd0, pc_wrap_o}, 44'd0);
    // Jump to 10 then to 0: no wrap pulse.
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h0A);
    drive(1'b0, 1'b0, 1'b1, 16'hC004, 1'b0, 1'b0, 8'h00);
    chk("jump_0a", {35'd0, pc_wrap_o, pc_o}, {35'd0, 1'b0, 8'h0A});
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h00);
    chk("jump_zero_nowrap", {27'd0, pc_wrap_o, pc_o, retired_o}, {27'd0, 1'b0, 8'h00, 8'd11});

    // Halt with jump at handoff, then start (with halt high) resumes at 0x40.
    drive(1'b0, 1'b0, 1'b1, 16'hC005, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h40);
    chk("halted", snap(), {1'b0, 8'h40, 1'b0, 16'hC005, 8'h40, 1'b0, 8'd12, 1'b0});
    drive(1'b0, 1'b1, 1'b1, 16'h5555, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 16'h5555, 1'b1, 1'b0, 8'h00);
    chk("halted_hold", snap(), {1'b0, 8'h40, 1'b0, 16'hC005, 8'h40, 1'b0, 8'd12, 1'b0});
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
    chk("restart_40", {34'd0, mem_req_o, mem_addr_o, busy_o}, {34'd0, 1'b1, 8'h40, 1'b1});

    // Reset in HOLD at pc 7.
    drive(1'b0, 1'b0, 1'b1, 16'hD000, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 8'h07);
    drive(1'b0, 1'b0, 1'b1, 16'hD007, 1'b0, 1'b0, 8'h00);
    chk("hold_pc7", {26'd0, instr_valid_o, instr_o, pc_o, retired_o[0]},
        {26'd0, 1'b1, 16'hD007, 8'h07, 1'b1});
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_reset", snap(), {1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0});
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1, 16'h7777, 1'b1, 1'b0, 8'h00);
      chk($sformatf("post_reset_idle%0d", i), snap(),
          {1'b0, 8'h00, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 1'b0});
    end
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
    chk("post_reset_start", {34'd0, mem_req_o, mem_addr_o, busy_o}, {34'd0, 1'b1, 8'h00, 1'b1});
    drive(1'b0, 1'b0, 1'b1, 16'hE000, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00);
    chk("post_reset_handoff", snap(), {1'b1, 8'h01, 1'b0, 16'hE000, 8'h01, 1'b0, 8'd1, 1'b1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
